commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Downstream consumer of the single-cycle core's retirement/writeback signals (pc, instr, reg_write, reg_waddr, reg_wdata).
- Buffers one trace record per retired instruction in a FIFO.
- Exposes the records through a valid/ready stream to a debug/UART trace drain or a bench scoreboard.
- Counts records dropped when full, so the consumer can detect gaps.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- XLEN, 32, data/pc width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on next rising clk).
- commit_valid  in  1  one instruction retires this cycle.
- pc  in  XLEN  pc of retiring instruction.
- instr  in  32  retiring instruction word.
- reg_write  in  1  register-file write enable from core.
- reg_waddr  in  5  destination register.
- reg_wdata  in  XLEN  writeback data.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head this cycle.
- out_seq  out  32  retire sequence number of head record.
- out_pc  out  XLEN  head pc.
- out_instr  out  32  head instruction.
- out_we  out  1  head record wrote an architectural register.
- out_rd  out  5  head destination (0 when out_we=0).
- out_wdata  out  XLEN  head write data (0 when out_we=0).
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow_cnt  out  16  dropped records, saturating at 16'hFFFF.
- overflow  out  1  sticky: at least one record dropped since reset.

Behaviour:
- Reset (rst=0 at clk edge):
  - Read/write pointers, count, seq counter, overflow_cnt and overflow clear to 0.
  - out_valid=0; all out_* data = 0.
  - Contents discarded, including reset mid-stream.
  - commit_valid during reset is ignored; seq does not advance.
- Record formation:
  - we = reg_write && (reg_waddr != 0).
  - rd = we ? reg_waddr : 0.
  - wdata = we ? reg_wdata : 0.
  - Stores with reg_write=0 and x0 writes record we=0.
- Sequence:
  - 32-bit seq counter increments on every commit_valid, including dropped ones; wraps at 2^32.
  - A record carries the seq value before the increment.
- Push: commit_valid && (count < DEPTH || pop).
- Pop: out_valid && out_ready.
- Drop: commit_valid && count==DEPTH && !pop.
  - Record is discarded.
  - overflow_cnt +1 (saturating); overflow set.
- count next value:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Simultaneous push+pop:
  - Legal at any occupancy, including full and empty-with-valid-head.
  - Full + push + pop accepts the new record; no drop.
- Output:
  - out_* are registered copies of the FIFO head. out_valid = (count != 0), registered.
  - Push into empty FIFO appears at outputs exactly 1 cycle later; no same-cycle bypass.
  - While out_valid && !out_ready, all out_* hold stable.
  - After a pop, the next head appears the following cycle with no bubble when count > 1.
  - When empty, out_* data hold the last popped values; consumers qualify with out_valid.
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.
- Ordering is strict FIFO; no reordering, no duplication.

Test Plan:
1. Reset with rst=0 for 2 cycles, then rst=1 -> count=0, out_valid=0, overflow_cnt=0, overflow=0, all out_* = 0.
2. Single commit, out_ready=1: pc=0, instr=32'h3E800093, reg_write=1, rd=1, wdata=32'h3E8. Required: next cycle out_valid=1, out_seq=0, out_we=1, out_rd=1, out_wdata=32'h3E8. Following cycle out_valid=0.
3. Store and x0 write:
   - sw at pc=32'h1C, reg_write=0, reg_waddr=8, reg_wdata=8 -> out_we=0, out_rd=0, out_wdata=0.
   - addi x0 with reg_write=1 -> out_we=0.
4. Overflow (DEPTH=4): out_ready=0, 6 consecutive commits -> count=4, overflow_cnt=2, overflow=1. Drain yields seq 0,1,2,3 in order with stable outputs under backpressure. Next commit carries seq=6.
5. Full push+pop: DEPTH=4 full, commit_valid=1 and out_ready=1 same cycle -> count stays 4, overflow_cnt unchanged, new record emerges after the 3 older ones.
6. Reset mid-operation: count=3, assert rst=0 with commit_valid=1 -> next cycle count=0, out_valid=0. First commit after release carries seq=0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures one record per retired instruction in a FIFO
// and streams it out over valid/ready, counting records dropped when full.
module commit_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     commit_valid,
   input  logic [XLEN-1:0]          pc,
   input  logic [31:0]              instr,
   input  logic                     reg_write,
   input  logic [4:0]               reg_waddr,
   input  logic [XLEN-1:0]          reg_wdata,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_seq,
   output logic [XLEN-1:0]          out_pc,
   output logic [31:0]              out_instr,
   output logic                     out_we,
   output logic [4:0]               out_rd,
   output logic [XLEN-1:0]          out_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic [15:0]              overflow_cnt,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [31:0]     seq;
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
      logic            we;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
   } rec_t;

   rec_t            mem [DEPTH];
   rec_t            head_q, head_nxt, new_rec;
   logic [PW-1:0]   rd_ptr, wr_ptr, rd_ptr_nxt;
   logic [CW-1:0]   count_q, count_nxt, remain;
   logic [31:0]     seq_q;
   logic            out_valid_q;
   logic            full, pop, push, drop;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      new_rec.seq   = seq_q;
      new_rec.pc    = pc;
      new_rec.instr = instr;
      new_rec.we    = reg_write && (reg_waddr != 5'd0);
      new_rec.rd    = new_rec.we ? reg_waddr : 5'd0;
      new_rec.wdata = new_rec.we ? reg_wdata : '0;

      full       = (count_q == CW'(DEPTH));
      pop        = out_valid_q && out_ready;
      push       = commit_valid && (!full || pop);
      drop       = commit_valid && full && !pop;
      rd_ptr_nxt = rd_ptr + PW'(pop);
      remain     = count_q - CW'(pop);
      count_nxt  = remain + CW'(push);

      // The head register is refilled from the incoming record only when
      // nothing older survives this cycle; otherwise from the next slot.
      head_nxt = head_q;
      if (count_nxt != '0)
         head_nxt = (push && remain == '0) ? new_rec : mem[rd_ptr_nxt];
   end

   // NOTE: the storage array has no reset; its contents are only trusted via count.
   always_ff @(posedge clk) begin
      if (rst && push)
         mem[wr_ptr] <= new_rec;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count_q      <= '0;
         seq_q        <= '0;
         overflow_cnt <= '0;
         overflow     <= 1'b0;
         out_valid_q  <= 1'b0;
         head_q       <= '0;
      end else begin
         rd_ptr      <= rd_ptr_nxt;
         count_q     <= count_nxt;
         out_valid_q <= (count_nxt != '0);
         head_q      <= head_nxt;
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (commit_valid)
            seq_q <= seq_q + 32'd1;
         if (drop) begin
            overflow <= 1'b1;
            if (overflow_cnt != 16'hFFFF)
               overflow_cnt <= overflow_cnt + 16'd1;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_seq   = head_q.seq;
   assign out_pc    = head_q.pc;
   assign out_instr = head_q.instr;
   assign out_we    = head_q.we;
   assign out_rd    = head_q.rd;
   assign out_wdata = head_q.wdata;
   assign count     = count_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench for commit_trace_buffer (DEPTH=4): directed commits push
// expected records; a negedge monitor compares every accepted head record.
module tb_commit_trace_buffer;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   typedef struct packed {
      logic [31:0] seq;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wdata;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        commit_valid;
   logic [31:0] pc, instr, reg_wdata;
   logic        reg_write;
   logic [4:0]  reg_waddr;
   logic        out_valid, out_ready;
   logic [31:0] out_seq, out_pc, out_instr, out_wdata;
   logic        out_we;
   logic [4:0]  out_rd;
   logic [2:0]  count;
   logic [15:0] overflow_cnt;
   logic        overflow;

   rec_t        exp_q[$];
   logic [31:0] exp_seq;
   int          n_checks = 0;
   int          n_pass   = 0;

   commit_trace_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .commit_valid(commit_valid), .pc(pc), .instr(instr),
      .reg_write(reg_write), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
      .out_pc(out_pc), .out_instr(out_instr), .out_we(out_we), .out_rd(out_rd),
      .out_wdata(out_wdata), .count(count), .overflow_cnt(overflow_cnt),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one commit for a single cycle; acc says whether it should be kept.
   task automatic commit(input logic [31:0] p, input logic [31:0] i, input logic rw,
                         input logic [4:0] wa, input logic [31:0] wd, input logic acc,
                         input logic ewe, input logic [4:0] erd, input logic [31:0] ewd);
      rec_t r;
      commit_valid = 1'b1;
      pc = p; instr = i; reg_write = rw; reg_waddr = wa; reg_wdata = wd;
      r = '{seq: exp_seq, pc: p, instr: i, we: ewe, rd: erd, wdata: ewd};
      tick();
      commit_valid = 1'b0;
      exp_seq = exp_seq + 32'd1;
      if (acc) exp_q.push_back(r);
   endtask

   task automatic reset_pulse();
      rst = 1'b0;
      repeat (2) tick();
      exp_q.delete();
      exp_seq = 32'd0;
      rst = 1'b1;
   endtask

   task automatic wait_empty(input string name);
      out_ready = 1'b1;
      for (int k = 0; k < 40 && (count != 3'd0 || exp_q.size() != 0); k++) tick();
      check(name, {63'd0, (count == 3'd0 && exp_q.size() == 0)}, 64'd1);
   endtask

   // Monitor: compare each accepted head, and check stability under backpressure.
   rec_t held;
   logic hold_prev = 1'b0;
   always @(negedge clk) begin
      rec_t cur, e;
      cur = '{seq: out_seq, pc: out_pc, instr: out_instr, we: out_we, rd: out_rd, wdata: out_wdata};
      if (rst && out_valid) begin
         if (hold_prev) check("stable_under_backpressure", cur, held);
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_record_seq", {32'd0, out_seq}, 64'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("rec_seq",   {32'd0, cur.seq},   {32'd0, e.seq});
               check("rec_pc",    {32'd0, cur.pc},    {32'd0, e.pc});
               check("rec_instr", {32'd0, cur.instr}, {32'd0, e.instr});
               check("rec_we",    {63'd0, cur.we},    {63'd0, e.we});
               check("rec_rd",    {59'd0, cur.rd},    {59'd0, e.rd});
               check("rec_wdata", {32'd0, cur.wdata}, {32'd0, e.wdata});
            end
         end
         hold_prev <= !out_ready;
         held      <= cur;
      end else begin
         hold_prev <= 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; commit_valid = 1'b0; out_ready = 1'b0;
      pc = '0; instr = '0; reg_write = 1'b0; reg_waddr = '0; reg_wdata = '0;
      exp_seq = 32'd0;

      // 1. Reset state
      reset_pulse();
      check("rst_count",     {61'd0, count}, 64'd0);
      check("rst_valid",     {63'd0, out_valid}, 64'd0);
      check("rst_ovf_cnt",   {48'd0, overflow_cnt}, 64'd0);
      check("rst_ovf",       {63'd0, overflow}, 64'd0);
      check("rst_out_seq",   {32'd0, out_seq}, 64'd0);
      check("rst_out_pc",    {32'd0, out_pc}, 64'd0);
      check("rst_out_instr", {32'd0, out_instr}, 64'd0);
      check("rst_out_we",    {63'd0, out_we}, 64'd0);
      check("rst_out_rd",    {59'd0, out_rd}, 64'd0);
      check("rst_out_wdata", {32'd0, out_wdata}, 64'd0);
      tick();

      // 2. Single commit: visible one cycle later, gone after the pop
      out_ready = 1'b1;
      commit(32'h0, 32'h3E80_0093, 1'b1, 5'd1, 32'h3E8, 1'b1, 1'b1, 5'd1, 32'h3E8);
      check("single_valid_next", {63'd0, out_valid}, 64'd1);
      tick();
      check("single_valid_after_pop", {63'd0, out_valid}, 64'd0);

      // 3. Store and x0 write both record we=0, rd=0, wdata=0
      commit(32'h1C, 32'h0081_2023, 1'b0, 5'd8, 32'h8, 1'b1, 1'b0, 5'd0, 32'h0);
      commit(32'h20, 32'h0050_0013, 1'b1, 5'd0, 32'h5, 1'b1, 1'b0, 5'd0, 32'h0);
      wait_empty("store_x0_drain");

      // 4. Overflow: six commits into a stalled DEPTH=4 buffer
      reset_pulse();
      out_ready = 1'b0;
      for (int n = 0; n < 6; n++)
         commit(32'h100 + 32'(4 * n), 32'h0000_0013 + 32'(n << 20), 1'b1, 5'(n + 2),
                32'hA0 + 32'(n), (n < 4), 1'b1, 5'(n + 2), 32'hA0 + 32'(n));
      check("ovf_count",   {61'd0, count}, 64'd4);
      check("ovf_cnt",     {48'd0, overflow_cnt}, 64'd2);
      check("ovf_sticky",  {63'd0, overflow}, 64'd1);
      for (int n = 0; n < 10; n++) begin
         out_ready = n[0];
         tick();
      end
      wait_empty("ovf_drain");
      commit(32'h200, 32'h0010_0093, 1'b1, 5'd1, 32'h1, 1'b1, 1'b1, 5'd1, 32'h1);
      wait_empty("seq6_drain");

      // 5. Full buffer with simultaneous push and pop
      out_ready = 1'b0;
      for (int n = 0; n < 4; n++)
         commit(32'h300 + 32'(4 * n), 32'h0000_0013, 1'b1, 5'd3, 32'(n), 1'b1, 1'b1, 5'd3, 32'(n));
      check("full_count", {61'd0, count}, 64'd4);
      out_ready = 1'b1;
      commit(32'h400, 32'h0000_0013, 1'b1, 5'd4, 32'h44, 1'b1, 1'b1, 5'd4, 32'h44);
      out_ready = 1'b0;
      check("pushpop_count",   {61'd0, count}, 64'd4);
      check("pushpop_ovf_cnt", {48'd0, overflow_cnt}, 64'd2);
      wait_empty("pushpop_drain");

      // 6. Reset mid-stream with a commit presented during reset
      out_ready = 1'b0;
      for (int n = 0; n < 3; n++)
         commit(32'h500 + 32'(4 * n), 32'h0000_0013, 1'b1, 5'd5, 32'(n), 1'b1, 1'b1, 5'd5, 32'(n));
      check("mid_count", {61'd0, count}, 64'd3);
      rst = 1'b0;
      commit_valid = 1'b1; pc = 32'h600; instr = 32'h0000_0013;
      tick();
      commit_valid = 1'b0;
      exp_q.delete();
      exp_seq = 32'd0;
      check("midrst_count", {61'd0, count}, 64'd0);
      check("midrst_valid", {63'd0, out_valid}, 64'd0);
      check("midrst_ovf",   {63'd0, overflow}, 64'd0);
      rst = 1'b1;
      tick();
      out_ready = 1'b1;
      commit(32'h700, 32'h0070_0393, 1'b1, 5'd7, 32'h7, 1'b1, 1'b1, 5'd7, 32'h7);
      wait_empty("post_reset_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
